fetch_unit: RTL and testbench

Instruction fetch stage sitting between the program counter and the decoder. It reads the PC address, issues byte reads to the memory bus, assembles opcode plus 0–2 operand bytes, and hands the complete instruction to the decoder over a valid/ready handshake. It drives the PC's `increment`, `lower_byte`, `branch` and `bra_add` controls, so the PC advances exactly once per byte consumed. Optionally it short-circuits absolute `JMP` (0x4C) by loading the target into the PC itself.

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the program counter and the decoder.
// It fetches the opcode and 0-2 operand bytes from the memory bus and presents
// the complete instruction on a valid/ready handshake. The PC advances once per
// byte consumed.
//
// Optional feature, enabled by defining FETCH_JMP_SHORTCUT_EN: absolute JMP
// (opcode 0x4C) loads its target into the PC directly through
// pc_lower_byte / pc_branch, so the next fetch starts at the jump target.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   pc_address                current PC value
//   pc_increment              one-cycle pulse, PC += 1
//   pc_lower_byte, pc_branch  PC target-load pulses, data on pc_bra_add
//   pc_bra_add                target byte; 0 when neither load pulse is high
//   mem_addr, mem_rd          read request, held until mem_ack
//   mem_rdata, mem_ack        read data and completion
//   fetch_flush               abort the fetch and restart at pc_address
//   ins_valid, ins_ready      instruction handshake towards the decoder
//   ins_opcode/op1/op2        instruction bytes, unused bytes are 0
//   ins_len                   instruction length 1..3 (0 after reset)
//
// state    | meaning
// RST_WAIT | one idle cycle after reset
// F_OP     | reading the opcode byte
// F_B1     | reading the first operand byte
// F_B2     | reading the second operand byte
// ISSUE    | instruction held on the outputs until accepted
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_address,
  output logic        pc_increment,
  output logic        pc_lower_byte,
  output logic        pc_branch,
  output logic [7:0]  pc_bra_add,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        fetch_flush,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_opcode,
  output logic [7:0]  ins_op1,
  output logic [7:0]  ins_op2,
  output logic [1:0]  ins_len
);

  typedef enum logic [2:0] {RST_WAIT, F_OP, F_B1, F_B2, ISSUE} state_t;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic [1:0] len_q, len_d;

  function automatic logic [1:0] len_of(input logic [7:0] op);
    if (op[3:0] == 4'h8 || op[3:0] == 4'hA ||
        op == 8'h00 || op == 8'h40 || op == 8'h60)
      return 2'd1;
    else if (op[3:2] == 2'b11 || op[4:0] == 5'b11001 || op == 8'h20)
      return 2'd3;
    else
      return 2'd2;
  endfunction

  // The PC advances on the same edge, so the next read sees the new address.
  assign mem_addr   = pc_address;
  assign ins_opcode = opcode_q;
  assign ins_op1    = op1_q;
  assign ins_op2    = op2_q;
  assign ins_len    = len_q;

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    len_d         = len_q;
    mem_rd        = 1'b0;
    ins_valid     = 1'b0;
    pc_increment  = 1'b0;
    pc_lower_byte = 1'b0;
    pc_branch     = 1'b0;
    pc_bra_add    = 8'h00;

    case (state_q)
      RST_WAIT: state_d = F_OP;
      F_OP: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          opcode_d     = mem_rdata;
          op1_d        = 8'h00;
          op2_d        = 8'h00;
          len_d        = len_of(mem_rdata);
          pc_increment = 1'b1;
          state_d      = (len_of(mem_rdata) == 2'd1) ? ISSUE : F_B1;
        end
      end
      F_B1: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          op1_d        = mem_rdata;
          pc_increment = 1'b1;
`ifdef FETCH_JMP_SHORTCUT_EN
          if (opcode_q == 8'h4C) begin
            pc_lower_byte = 1'b1;
            pc_bra_add    = mem_rdata;
          end
`endif
          state_d = (len_q == 2'd2) ? ISSUE : F_B2;
        end
      end
      F_B2: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          op2_d   = mem_rdata;
          state_d = ISSUE;
`ifdef FETCH_JMP_SHORTCUT_EN
          // The branch replaces the increment: the PC jumps straight to the target.
          if (opcode_q == 8'h4C) begin
            pc_branch  = 1'b1;
            pc_bra_add = mem_rdata;
          end else begin
            pc_increment = 1'b1;
          end
`else
          pc_increment = 1'b1;
`endif
        end
      end
      ISSUE: begin
        ins_valid = 1'b1;
        if (ins_ready) begin
          op1_d   = 8'h00;
          op2_d   = 8'h00;
          state_d = F_OP;
        end
      end
      default: state_d = RST_WAIT;
    endcase

    // Flush wins over everything: drop any coincident ack or handshake.
    if (fetch_flush) begin
      state_d       = F_OP;
      opcode_d      = opcode_q;
      len_d         = len_q;
      op1_d         = 8'h00;
      op2_d         = 8'h00;
      mem_rd        = 1'b0;
      ins_valid     = 1'b0;
      pc_increment  = 1'b0;
      pc_lower_byte = 1'b0;
      pc_branch     = 1'b0;
      pc_bra_add    = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_WAIT;
      opcode_q <= 8'h00;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      len_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc_address;
  logic        pc_increment, pc_lower_byte, pc_branch;
  logic [7:0]  pc_bra_add;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        fetch_flush;
  logic        ins_valid, ins_ready;
  logic [7:0]  ins_opcode, ins_op1, ins_op2;
  logic [1:0]  ins_len;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_address(pc_address),
    .pc_increment(pc_increment), .pc_lower_byte(pc_lower_byte),
    .pc_branch(pc_branch), .pc_bra_add(pc_bra_add),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .fetch_flush(fetch_flush),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_opcode(ins_opcode), .ins_op1(ins_op1), .ins_op2(ins_op2),
    .ins_len(ins_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  pc_low;
  always @(posedge clk) begin
    if (pc_load) pc_address <= pc_load_val;
    else begin
      if (pc_branch) pc_address <= {pc_bra_add, pc_low};
      else if (pc_increment) pc_address <= pc_address + 16'd1;
      if (pc_lower_byte) pc_low <= pc_bra_add;
    end
  end

  // Memory with a configurable number of wait cycles per read
  logic [7:0] mem [0:65535];
  logic [3:0] wait_cfg, wcnt;
  logic       ack_force;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (mem_rd && (wcnt == wait_cfg)) || ack_force;
  always @(posedge clk) begin
    if (!mem_rd || mem_ack) wcnt <= 4'd0;
    else wcnt <= wcnt + 4'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] pc);
    rst = 1'b1; pc_load = 1'b1; pc_load_val = pc;
    ins_ready = 1'b0; fetch_flush = 1'b0; ack_force = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_len", 32'(ins_len), 32'd0);
    chk("rst_opcode", 32'(ins_opcode), 32'd0);
    chk("rst_pc_pulses", 32'({pc_increment, pc_lower_byte, pc_branch}), 32'd0);
    chk("rst_bra_add", 32'(pc_bra_add), 32'd0);
    rst = 1'b0; pc_load = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  b0, b1, b2;
    logic [3:0]  w;
    logic [7:0]  op1, op2;
    logic [1:0]  len;
    int          cyc, incs, lbs, brs;
    logic [7:0]  lbv, brv;
    logic [15:0] nxt;
  } vec_t;

  function automatic vec_t mk(logic [15:0] pc, logic [7:0] b0, b1, b2, logic [3:0] w,
                              logic [7:0] op1, op2, logic [1:0] len, int cyc, incs,
                              int lbs, brs, logic [7:0] lbv, brv, logic [15:0] nxt);
    vec_t v;
    v.pc = pc; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.w = w; v.op1 = op1; v.op2 = op2;
    v.len = len; v.cyc = cyc; v.incs = incs; v.lbs = lbs; v.brs = brs;
    v.lbv = lbv; v.brv = brv; v.nxt = nxt;
    return v;
  endfunction

  vec_t vec [11];

  initial begin
    vec_t v;
    int cyc, inc_n, lb_n, br_n, viol;
    logic [7:0] lb_val, br_val;
    logic prev_rd, prev_ack;
    logic [15:0] prev_addr, a;

    for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    rst = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0; wait_cfg = 4'd0;
    ack_force = 1'b0; fetch_flush = 1'b0; ins_ready = 1'b0; pc_low = 8'h00;

    //            pc       b0     b1     b2     w     op1    op2    len cyc inc lb br lbv    brv    next
    vec[0]  = mk(16'hFFCA, 8'hEA, 8'h00, 8'h00, 4'd0, 8'h00, 8'h00, 2'd1, 2, 1, 0, 0, 8'h00, 8'h00, 16'hFFCB);
    vec[1]  = mk(16'h0200, 8'hA9, 8'h42, 8'h00, 4'd0, 8'h42, 8'h00, 2'd2, 3, 2, 0, 0, 8'h00, 8'h00, 16'h0202);
    vec[2]  = mk(16'h0300, 8'hAD, 8'h34, 8'h12, 4'd3, 8'h34, 8'h12, 2'd3, 13, 3, 0, 0, 8'h00, 8'h00, 16'h0303);
`ifdef FETCH_JMP_SHORTCUT_EN
    vec[3]  = mk(16'h1000, 8'h4C, 8'h00, 8'h80, 4'd0, 8'h00, 8'h80, 2'd3, 4, 2, 1, 1, 8'h00, 8'h80, 16'h8000);
`else
    vec[3]  = mk(16'h1000, 8'h4C, 8'h00, 8'h80, 4'd0, 8'h00, 8'h80, 2'd3, 4, 3, 0, 0, 8'h00, 8'h00, 16'h1003);
`endif
    vec[4]  = mk(16'h4000, 8'h00, 8'h77, 8'h88, 4'd0, 8'h00, 8'h00, 2'd1, 2, 1, 0, 0, 8'h00, 8'h00, 16'h4001);
    vec[5]  = mk(16'h5000, 8'h20, 8'h34, 8'h12, 4'd1, 8'h34, 8'h12, 2'd3, 7, 3, 0, 0, 8'h00, 8'h00, 16'h5003);
    vec[6]  = mk(16'h6000, 8'h19, 8'hAB, 8'hCD, 4'd0, 8'hAB, 8'hCD, 2'd3, 4, 3, 0, 0, 8'h00, 8'h00, 16'h6003);
    vec[7]  = mk(16'h7000, 8'h60, 8'h11, 8'h22, 4'd2, 8'h00, 8'h00, 2'd1, 4, 1, 0, 0, 8'h00, 8'h00, 16'h7001);
    vec[8]  = mk(16'h7100, 8'h48, 8'h11, 8'h22, 4'd0, 8'h00, 8'h00, 2'd1, 2, 1, 0, 0, 8'h00, 8'h00, 16'h7101);
    vec[9]  = mk(16'h7200, 8'hA0, 8'h05, 8'h22, 4'd0, 8'h05, 8'h00, 2'd2, 3, 2, 0, 0, 8'h00, 8'h00, 16'h7202);
    vec[10] = mk(16'h7300, 8'h40, 8'h99, 8'h99, 4'd1, 8'h00, 8'h00, 2'd1, 3, 1, 0, 0, 8'h00, 8'h00, 16'h7301);

    for (int i = 0; i < 11; i++) begin
      v = vec[i];
      a = v.pc; mem[a] = v.b0;
      a = a + 16'd1; mem[a] = v.b1;
      a = a + 16'd1; mem[a] = v.b2;
      wait_cfg = v.w;
      do_reset(v.pc);
      cyc = 0; inc_n = 0; lb_n = 0; br_n = 0; viol = 0;
      lb_val = 8'h00; br_val = 8'h00;
      prev_rd = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0;
      while (cyc < 60) begin
        @(negedge clk); #1;
        cyc++;
        if (prev_rd && !prev_ack && (!mem_rd || mem_addr !== prev_addr)) viol++;
        if (pc_increment) inc_n++;
        if (pc_lower_byte) begin lb_n++; lb_val = pc_bra_add; end
        if (pc_branch) begin br_n++; br_val = pc_bra_add; end
        if (!pc_lower_byte && !pc_branch && pc_bra_add != 8'h00) viol++;
        if (pc_branch && (pc_increment || pc_lower_byte)) viol++;
        prev_rd = mem_rd; prev_ack = mem_ack; prev_addr = mem_addr;
        if (ins_valid) break;
      end
      chk($sformatf("v%0d_valid_cycle", i), 32'(cyc), 32'(v.cyc));
      chk($sformatf("v%0d_opcode", i), 32'(ins_opcode), 32'(v.b0));
      chk($sformatf("v%0d_op1", i), 32'(ins_op1), 32'(v.op1));
      chk($sformatf("v%0d_op2", i), 32'(ins_op2), 32'(v.op2));
      chk($sformatf("v%0d_len", i), 32'(ins_len), 32'(v.len));
      chk($sformatf("v%0d_mem_rd_issue", i), 32'(mem_rd), 32'd0);
      chk($sformatf("v%0d_incs", i), 32'(inc_n), 32'(v.incs));
      chk($sformatf("v%0d_lower_pulses", i), 32'(lb_n), 32'(v.lbs));
      chk($sformatf("v%0d_branch_pulses", i), 32'(br_n), 32'(v.brs));
      chk($sformatf("v%0d_protocol", i), 32'(viol), 32'd0);
      if (v.lbs != 0) chk($sformatf("v%0d_lower_val", i), 32'(lb_val), 32'(v.lbv));
      if (v.brs != 0) chk($sformatf("v%0d_branch_val", i), 32'(br_val), 32'(v.brv));
      ins_ready = 1'b1;
      @(negedge clk); ins_ready = 1'b0; #1;
      chk($sformatf("v%0d_valid_cleared", i), 32'(ins_valid), 32'd0);
      chk($sformatf("v%0d_next_rd", i), 32'(mem_rd), 32'd1);
      chk($sformatf("v%0d_next_addr", i), 32'(mem_addr), 32'(v.nxt));
      chk($sformatf("v%0d_op1_cleared", i), 32'(ins_op1), 32'd0);
    end

    // Flush coincident with the op1 ack: no PC pulse, refetch at unchanged PC.
    mem[16'h0700] = 8'hA9; mem[16'h0701] = 8'h55;
    wait_cfg = 4'd0;
    do_reset(16'h0700);
    @(negedge clk); #1;
    chk("flush_opcode_inc", 32'(pc_increment), 32'd1);
    @(negedge clk);
    fetch_flush = 1'b1; ack_force = 1'b1; #1;
    chk("flush_no_inc", 32'(pc_increment), 32'd0);
    chk("flush_no_rd", 32'(mem_rd), 32'd0);
    chk("flush_no_lower", 32'(pc_lower_byte), 32'd0);
    @(negedge clk);
    fetch_flush = 1'b0; ack_force = 1'b0; #1;
    chk("flush_refetch_rd", 32'(mem_rd), 32'd1);
    chk("flush_refetch_addr", 32'(mem_addr), 32'h0701);
    chk("flush_op1_zero", 32'(ins_op1), 32'd0);

    // Decoder stall in ISSUE with stray acks, then reset pulse during ISSUE.
    do_reset(16'h0200);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (ins_valid) break;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ack_force = 1'b1; #1;
      chk($sformatf("stall%0d_valid", c), 32'(ins_valid), 32'd1);
      chk($sformatf("stall%0d_bytes", c), 32'({ins_opcode, ins_op1, ins_op2}), 32'hA94200);
      chk($sformatf("stall%0d_len", c), 32'(ins_len), 32'd2);
      chk($sformatf("stall%0d_mem_rd", c), 32'(mem_rd), 32'd0);
      chk($sformatf("stall%0d_no_inc", c), 32'(pc_increment), 32'd0);
    end
    ack_force = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("issue_rst_valid", 32'(ins_valid), 32'd0);
    chk("issue_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("issue_rst_bytes", 32'({ins_opcode, ins_op1, ins_op2}), 32'd0);
    chk("issue_rst_len", 32'(ins_len), 32'd0);
    chk("issue_rst_pulses", 32'({pc_increment, pc_lower_byte, pc_branch}), 32'd0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
